// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the load/store control sequencer family.
// Register indices name bit positions in the one-hot bus select / enable words.
package mem_seq_pkg;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, T6W, T7
    } state_t;

    localparam logic [4:0] OP_LD  = 5'd0;
    localparam logic [4:0] OP_LDI = 5'd1;
    localparam logic [4:0] OP_ST  = 5'd2;

    localparam logic [5:0] ALU_ADD = 6'd0;

    localparam int IDX_ZLO = 19;
    localparam int IDX_PC  = 20;
    localparam int IDX_IR  = 21;
    localparam int IDX_MDR = 22;
    localparam int IDX_MAR = 23;
    localparam int IDX_Y   = 24;
    localparam int IDX_C   = 25;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter with timeout compare. Held at zero while clear is high,
// so it always starts from zero when a wait state is entered.
module mem_wait_timer #(
    parameter int WAIT_MAX = 7
) (
    input  logic clock,
    input  logic clr,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/mem_op_sequencer.sv
// Fetch / ld / ldi / st control sequencer. Memory accesses wait on mem_ready
// and abort with mem_err if it stays low for WAIT_MAX cycles.
module mem_op_sequencer
    import mem_seq_pkg::*;
#(
    parameter int SEL_W    = 32,
    parameter int OPC_W    = 5,
    parameter int WAIT_MAX = 7
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic [SEL_W-1:0] enc_input,
    output logic [SEL_W-1:0] reg_enable,
    output logic [5:0]       alu_sel,
    output logic             read,
    output logic             write,
    output logic             inc_pc,
    output logic             gra,
    output logic             grb,
    output logic             grc,
    output logic             r_in,
    output logic             r_out,
    output logic             ba_out,
    output logic             busy,
    output logic             done,
    output logic             mem_err,
    output logic             illegal
);
    state_t           state_reg, state_next;
    logic [OPC_W-1:0] op_reg;
    logic             in_wait, expired, timeout;
    logic             op_is_ld, op_is_ldi;

    function automatic logic [SEL_W-1:0] onehot(input int idx);
        onehot = SEL_W'(1) << idx;
    endfunction

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        is_legal = (op == OPC_W'(OP_LD)) || (op == OPC_W'(OP_LDI)) ||
                   (op == OPC_W'(OP_ST));
    endfunction

    // Opcode is captured at decode so later steps do not depend on the IR field.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == T3) begin
                op_reg <= opcode;
            end
        end
    end

    assign op_is_ld  = (op_reg == OPC_W'(OP_LD));
    assign op_is_ldi = (op_reg == OPC_W'(OP_LDI));
    assign in_wait   = (state_reg == T1W) || (state_reg == T6W) ||
                       ((state_reg == T6) && op_is_ld);
    assign timeout   = in_wait && !mem_ready && expired;

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .clock    (clock),
        .clr      (clr),
        .clear    (!in_wait),
        .count_en (in_wait && !mem_ready),
        .expired  (expired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = T0;
            T0:   state_next = T1;
            T1:   state_next = T1W;
            T1W:  if (mem_ready) state_next = T2;
                  else if (timeout) state_next = IDLE;
            T2:   state_next = T3;
            T3:   state_next = is_legal(opcode) ? T4 : IDLE;
            T4:   state_next = T5;
            T5:   state_next = op_is_ldi ? IDLE : T6;
            T6:   if (!op_is_ld) state_next = T6W;
                  else if (mem_ready) state_next = T7;
                  else if (timeout) state_next = IDLE;
            T6W:  if (mem_ready || timeout) state_next = IDLE;
            T7:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enc_input  = '0;
        reg_enable = '0;
        alu_sel    = ALU_ADD;
        read       = 1'b0;
        write      = 1'b0;
        inc_pc     = 1'b0;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        r_in       = 1'b0;
        r_out      = 1'b0;
        ba_out     = 1'b0;
        done       = 1'b0;
        mem_err    = 1'b0;
        illegal    = 1'b0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            T0: begin
                enc_input  = onehot(IDX_PC);
                reg_enable = onehot(IDX_MAR) | onehot(IDX_ZLO);
                inc_pc     = 1'b1;
            end
            T1: begin
                enc_input  = onehot(IDX_ZLO);
                reg_enable = onehot(IDX_PC);
                read       = 1'b1;
            end
            T1W: begin
                read    = !timeout;
                mem_err = timeout;
                if (mem_ready) reg_enable = onehot(IDX_MDR);
            end
            T2: begin
                enc_input  = onehot(IDX_MDR);
                reg_enable = onehot(IDX_IR);
            end
            T3: begin
                grb        = 1'b1;
                ba_out     = 1'b1;
                reg_enable = onehot(IDX_Y);
                illegal    = !is_legal(opcode);
            end
            T4: begin
                enc_input  = onehot(IDX_C);
                alu_sel    = ALU_ADD;
                reg_enable = onehot(IDX_ZLO);
            end
            T5: begin
                enc_input = onehot(IDX_ZLO);
                if (op_is_ldi) begin
                    gra  = 1'b1;
                    r_in = 1'b1;
                    done = 1'b1;
                end else begin
                    reg_enable = onehot(IDX_MAR);
                end
            end
            T6: begin
                if (op_is_ld) begin
                    read    = !timeout;
                    mem_err = timeout;
                    if (mem_ready) reg_enable = onehot(IDX_MDR);
                end else begin
                    gra        = 1'b1;
                    r_out      = 1'b1;
                    reg_enable = onehot(IDX_MDR);
                end
            end
            T6W: begin
                write   = !timeout;
                mem_err = timeout;
                done    = mem_ready;
            end
            T7: begin
                enc_input = onehot(IDX_MDR);
                gra       = 1'b1;
                r_in      = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Cycle-by-cycle check of mem_op_sequencer against an instruction-level model
// that expands each instruction and its memory latencies into expected outputs.
module tb_mem_op_sequencer;
    localparam int WAIT_MAX = 7;
    localparam int I_ZLO = 19, I_PC = 20, I_IR = 21, I_MDR = 22;
    localparam int I_MAR = 23, I_Y = 24, I_C = 25;

    typedef struct packed {
        logic [31:0] enc;
        logic [31:0] en;
        logic [5:0]  alu;
        logic read, write, inc_pc, gra, grb, grc, r_in, r_out, ba_out;
        logic busy, done, mem_err, illegal;
    } outs_t;

    logic        clock = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [31:0] enc_input, reg_enable;
    logic [5:0]  alu_sel;
    logic read, write, inc_pc, gra, grb, grc, r_in, r_out, ba_out;
    logic busy, done, mem_err, illegal;

    mem_op_sequencer dut (
        .clock(clock), .clr(clr), .start(start), .opcode(opcode),
        .mem_ready(mem_ready), .enc_input(enc_input), .reg_enable(reg_enable),
        .alu_sel(alu_sel), .read(read), .write(write), .inc_pc(inc_pc),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
        .ba_out(ba_out), .busy(busy), .done(done), .mem_err(mem_err),
        .illegal(illegal)
    );

    always #5 clock = ~clock;

    outs_t obs;
    assign obs = {enc_input, reg_enable, alu_sel, read, write, inc_pc, gra, grb,
                  grc, r_in, r_out, ba_out, busy, done, mem_err, illegal};

    int    vectors = 0;
    int    miscompares = 0;
    outs_t exp_q[$];
    bit    mr_q[$];
    outs_t obs_q[$];

    function automatic logic [31:0] bit_at(input int i);
        bit_at = 32'd1 << i;
    endfunction

    task automatic push(input outs_t o, input bit mr);
        exp_q.push_back(o);
        mr_q.push_back(mr);
    endtask

    // A wait phase: d low cycles then ready; ready never arrives if d > WAIT_MAX.
    task automatic add_wait(input int d, input outs_t base, input outs_t succ,
                            output bit ok);
        ok = 1'b0;
        for (int k = 0; k <= WAIT_MAX; k++) begin
            if (k == d) begin
                push(succ, 1'b1);
                ok = 1'b1;
                return;
            end
            if (k == WAIT_MAX) begin
                outs_t t;
                t = '0;
                t.busy = 1'b1;
                t.mem_err = 1'b1;
                push(t, 1'b0);
                return;
            end
            push(base, 1'b0);
        end
    endtask

    task automatic build(input logic [4:0] op, input int d1, input int d6);
        outs_t o, s, b;
        bit ok;
        exp_q.delete();
        mr_q.delete();
        b = '0;
        b.busy = 1'b1;
        o = '0;
        push(o, 1'($urandom_range(0, 1)));
        o = b; o.enc = bit_at(I_PC); o.en = bit_at(I_MAR) | bit_at(I_ZLO); o.inc_pc = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
        o = b; o.enc = bit_at(I_ZLO); o.en = bit_at(I_PC); o.read = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
        o = b; o.read = 1'b1; s = o; s.en = bit_at(I_MDR);
        add_wait(d1, o, s, ok);
        if (!ok) return;
        o = b; o.enc = bit_at(I_MDR); o.en = bit_at(I_IR);
        push(o, 1'($urandom_range(0, 1)));
        o = b; o.grb = 1'b1; o.ba_out = 1'b1; o.en = bit_at(I_Y);
        if (op > 5'd2) begin
            o.illegal = 1'b1;
            push(o, 1'($urandom_range(0, 1)));
            return;
        end
        push(o, 1'($urandom_range(0, 1)));
        o = b; o.enc = bit_at(I_C); o.en = bit_at(I_ZLO);
        push(o, 1'($urandom_range(0, 1)));
        o = b; o.enc = bit_at(I_ZLO);
        if (op == 5'd1) begin
            o.gra = 1'b1; o.r_in = 1'b1; o.done = 1'b1;
            push(o, 1'($urandom_range(0, 1)));
            return;
        end
        o.en = bit_at(I_MAR);
        push(o, 1'($urandom_range(0, 1)));
        if (op == 5'd0) begin
            o = b; o.read = 1'b1; s = o; s.en = bit_at(I_MDR);
            add_wait(d6, o, s, ok);
            if (!ok) return;
            o = b; o.enc = bit_at(I_MDR); o.gra = 1'b1; o.r_in = 1'b1; o.done = 1'b1;
            push(o, 1'($urandom_range(0, 1)));
        end else begin
            o = b; o.gra = 1'b1; o.r_out = 1'b1; o.en = bit_at(I_MDR);
            push(o, 1'($urandom_range(0, 1)));
            o = b; o.write = 1'b1; s = o; s.done = 1'b1;
            add_wait(d6, o, s, ok);
        end
    endtask

    // Caller is 1 time unit past a rising edge with the DUT idle.
    task automatic run_instr(input logic [4:0] op, input int d1, input int d6,
                             input int abort_idx, input bit chain);
        build(op, d1, d6);
        obs_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            mem_ready = mr_q[i];
            opcode = op;
            #1;
            obs_q.push_back(obs);
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++;
                $display("FAIL cycle op=%0d d1=%0d d6=%0d idx=%0d got=%h want=%h",
                         op, d1, d6, i, obs, exp_q[i]);
            end
            if (i == abort_idx) begin
                #1 clr = 1'b1;
                #1;
                vectors++;
                if (obs !== '0) begin
                    miscompares++;
                    $display("FAIL async_clr got=%h want=0", obs);
                end
                @(posedge clock);
                #1 clr = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        if (!chain) begin
            start = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (obs !== '0) begin
                miscompares++;
                $display("FAIL idle_after op=%0d got=%h want=0", op, obs);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        #2 clr = 1'b1;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
        start = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_hold got=%h want=0", obs);
        end
        clr = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_ld();
        int n_done;
        outs_t last;
        run_instr(5'd0, 0, 0, -1, 1'b0);
        n_done = 0;
        foreach (obs_q[i]) if (obs_q[i].done) n_done++;
        last = obs_q[obs_q.size()-1];
        vectors++;
        if (n_done != 1 || obs_q.size() != 10) begin
            miscompares++;
            $display("FAIL ld_shape got done=%0d len=%0d want done=1 len=10", n_done, obs_q.size());
        end
        vectors++;
        if (last.enc !== bit_at(I_MDR) || last.gra !== 1'b1 || last.r_in !== 1'b1) begin
            miscompares++;
            $display("FAIL ld_t7 got enc=%h gra=%b r_in=%b want enc=%h gra=1 r_in=1",
                     last.enc, last.gra, last.r_in, bit_at(I_MDR));
        end
    endtask

    task automatic test_ldi();
        outs_t last;
        run_instr(5'd1, 0, 0, -1, 1'b0);
        last = obs_q[obs_q.size()-1];
        vectors++;
        if (obs_q.size() != 8 || last.enc !== bit_at(I_ZLO) || last.done !== 1'b1) begin
            miscompares++;
            $display("FAIL ldi_t5 got len=%0d enc=%h done=%b want len=8 enc=%h done=1",
                     obs_q.size(), last.enc, last.done, bit_at(I_ZLO));
        end
    endtask

    task automatic test_st();
        int n_wr, n_mdr;
        run_instr(5'd2, 0, 3, -1, 1'b0);
        n_wr = 0;
        n_mdr = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].write) n_wr++;
            if (obs_q[i].en == bit_at(I_MDR)) n_mdr++;
        end
        vectors++;
        if (n_wr != 4 || n_mdr != 2 || obs_q[obs_q.size()-1].done !== 1'b1) begin
            miscompares++;
            $display("FAIL st_write got write=%0d mdr_en=%0d want write=4 mdr_en=2", n_wr, n_mdr);
        end
    endtask

    task automatic test_timeout();
        int n_rd;
        outs_t last;
        run_instr(5'd0, WAIT_MAX + 1, 0, -1, 1'b0);
        n_rd = 0;
        foreach (obs_q[i]) if (obs_q[i].read) n_rd++;
        last = obs_q[obs_q.size()-1];
        vectors++;
        if (n_rd != WAIT_MAX + 1 || last.mem_err !== 1'b1 || last.en !== '0 || last.read !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout got read_cycles=%0d mem_err=%b en=%h want read_cycles=%0d mem_err=1 en=0",
                     n_rd, last.mem_err, last.en, WAIT_MAX + 1);
        end
        run_instr(5'd0, 0, WAIT_MAX + 2, -1, 1'b0);
        run_instr(5'd2, 1, WAIT_MAX + 1, -1, 1'b0);
        run_instr(5'd0, WAIT_MAX, WAIT_MAX, -1, 1'b0);
        run_instr(5'd2, WAIT_MAX, WAIT_MAX, -1, 1'b0);
    endtask

    task automatic test_illegal();
        int n_y;
        run_instr(5'd31, 0, 0, -1, 1'b0);
        n_y = 0;
        foreach (obs_q[i]) if (obs_q[i].en[I_Y]) n_y++;
        vectors++;
        if (n_y != 1 || obs_q[obs_q.size()-1].illegal !== 1'b1 || obs_q.size() != 6) begin
            miscompares++;
            $display("FAIL illegal got y_en=%0d illegal=%b len=%0d want y_en=1 illegal=1 len=6",
                     n_y, obs_q[obs_q.size()-1].illegal, obs_q.size());
        end
    endtask

    task automatic test_clr_mid_t6();
        run_instr(5'd0, 0, 5, 10, 1'b0);
        run_instr(5'd2, 2, 1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_instr(5'd1, 0, 0, -1, 1'b1);
        run_instr(5'd0, 2, 1, -1, 1'b1);
        run_instr(5'd2, 0, 2, -1, 1'b1);
        run_instr(5'd9, 1, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: op = 5'd0;
                1: op = 5'd1;
                2: op = 5'd2;
                default: op = 5'($urandom_range(3, 31));
            endcase
            run_instr(op, $urandom_range(0, WAIT_MAX + 2), $urandom_range(0, WAIT_MAX + 2),
                      -1, 1'($urandom_range(0, 1)));
        end
        start = 1'b0;
        #1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ld();
        test_ldi();
        test_st();
        test_timeout();
        test_illegal();
        test_clr_mid_t6();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_op_sequencer.md
Name: mem_op_sequencer

Overview:
- Parametrised control sequencer for load/store-class instructions.
- Drives the datapath control word each cycle: bus source select (enc_input), register enables, ALU select, memory read/write, Gra/Grb/Grc/Rin/Rout/BAout and inc_pc.
- Runs instruction fetch (T0–T2), then ld, ldi or st execution.
- Replaces fixed-delay memory timing with a mem_ready handshake plus a bounded wait-state timeout.

Parameters:
- SEL_W, 32, width of enc_input and reg_enable
- OPC_W, 5, opcode width
- OP_LD, 5'd0, ld opcode
- OP_LDI, 5'd1, ldi opcode
- OP_ST, 5'd2, st opcode
- ALU_ADD, 6'd0, alu_sel code for add
- IDX_ZLO, 19, Zlow index
- IDX_PC, 20, PC index
- IDX_IR, 21, IR index
- IDX_MDR, 22, MDR index
- IDX_MAR, 23, MAR index
- IDX_Y, 24, Y index
- IDX_C, 25, C-sign-extended index
- WAIT_MAX, 7, maximum cycles mem_ready may stay low (≥1)

Ports:
- clock, in, 1: rising-edge clock
- clr, in, 1: asynchronous active-high reset
- start, in, 1: begin one instruction (sampled in IDLE)
- opcode, in, OPC_W: IR opcode field, valid from T3 onward
- mem_ready, in, 1: memory completes the current read/write
- enc_input, out, SEL_W: one-hot bus source select
- reg_enable, out, SEL_W: register load enables
- alu_sel, out, 6: ALU operation
- read, out, 1: memory read
- write, out, 1: memory write
- inc_pc, out, 1: PC increment
- gra, grb, grc, r_in, r_out, ba_out, out, 1 each: register-file select/control
- busy, out, 1: high in every state except IDLE
- done, out, 1: one-cycle pulse on normal completion
- mem_err, out, 1: one-cycle pulse on timeout
- illegal, out, 1: one-cycle pulse on unknown opcode

Behaviour:
- Moore outputs, combinationally decoded from the registered state. Unlisted signals are 0 in each state. alu_sel = ALU_ADD whenever it is unused.
- Reset (async, any time, including mid-operation): state=IDLE, wait counter=0, all outputs 0. The next instruction needs a fresh start.
- IDLE:
  - start=1 -> T0.
  - start is ignored while busy.
- Fetch:
  - T0: enc[PC], en[MAR], inc_pc, en[ZLO] -> T1.
  - T1: enc[ZLO], en[PC], read -> T1W.
  - T1W: read held.
    - mem_ready=1: en[MDR], go to T2.
    - else wait counter +1.
  - T2: enc[MDR], en[IR] -> T3.
- T3 (opcode decoded here): grb, ba_out, en[Y].
  - ld/ldi/st -> T4.
  - Otherwise pulse illegal -> IDLE.
- T4: enc[C], alu_sel=ALU_ADD, en[ZLO] -> T5.
- T5 by opcode:
  - ldi: enc[ZLO], gra, r_in, done -> IDLE.
  - ld/st: enc[ZLO], en[MAR] -> T6.
- T6:
  - ld: read; on mem_ready, en[MDR] and go to T7.
  - st: gra, r_out, en[MDR] -> T6W.
- T6W (st only): write held until mem_ready -> done -> IDLE.
- T7 (ld only): enc[MDR], gra, r_in, done -> IDLE.
- Wait counter:
  - $clog2(WAIT_MAX+1) bits.
  - Cleared on entry to each wait state (T1W, T6 for ld, T6W).
  - Increments each cycle mem_ready=0.
  - Reaches WAIT_MAX with mem_ready still 0: pulse mem_err, drop read/write, go to IDLE. No register enable is asserted in that cycle.
- mem_ready is ignored outside wait states.
- Simultaneous mem_ready and counter==WAIT_MAX: mem_ready wins (normal progress).
- enc_input is one-hot or zero in every state. No two bus drivers are active at once; ba_out counts as a driver.

Decomposition:
- Shared package mem_seq_pkg:
  - state enum (IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, T6W, T7)
  - opcode constants
  - ALU code constants
  - register index constants
- Optional sub-module mem_wait_timer (counter + timeout compare), reusable by future I/O sequencers.
- Everything else stays in one module.

Test Plan:
- ld, mem_ready=1 on the first cycle of each wait state -> states IDLE,T0,T1,T1W,T2,T3,T4,T5,T6,T7 ending in IDLE; done pulses once in T7; T7 shows enc_input=1<<22, gra=1, r_in=1.
- ldi (opcode=1) -> T5 asserts enc_input=1<<19, gra, r_in, done; no T6/T7; busy low the next cycle.
- st (opcode=2), mem_ready delayed 3 cycles in T6W -> write high 4 cycles, done when mem_ready=1, reg_enable=1<<22 only in T6.
- Timeout: mem_ready held 0 in T1W with WAIT_MAX=7 -> read stays high 7 cycles, then mem_err pulses, state IDLE, reg_enable=0.
- opcode=5'd31 at T3 -> illegal pulses, IDLE next cycle, no reg_enable[24] beyond T3.
- clr asserted mid-T6 with read=1 -> all outputs 0 immediately (asynchronous); start after deassert restarts at T0.
